// File: rtl/axis_eth_rx_mac_filter.sv
// ============================================================================
// axis_eth_rx_mac_filter : destination-MAC filter for a byte-wide RX stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_eth_rx_mac_filter #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int COUNT_WIDTH = 32,
    parameter int IDLE_GAP    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic [USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    input  logic [47:0]            cfg_local_mac,
    input  logic                   cfg_promisc,
    input  logic                   cfg_bcast_enable,
    input  logic                   cfg_mcast_enable,
    output logic                   stat_frame_accept,
    output logic                   stat_drop_addr,
    output logic                   stat_drop_runt,
    output logic                   stat_overflow,
    output logic [COUNT_WIDTH-1:0] stat_drop_count
);

    localparam logic [2:0] ST_RESYNC = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_HEADER = 3'd2;
    localparam logic [2:0] ST_PASS   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DROP   = 3'd5;
    localparam int         GAP_W     = $clog2(IDLE_GAP + 1);

    generate
        if (DATA_WIDTH != 8) begin : g_bad_width
            $error("axis_eth_rx_mac_filter: only DATA_WIDTH = 8 is supported");
        end
    endgenerate

    logic [2:0]             state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   ovf_seen_q, ovf_seen_d;
    logic                   ovf_open_q, ovf_open_d;

    logic [DATA_WIDTH-1:0]  buf_data_q [6];
    logic                   buf_last_q [6];
    logic [USER_WIDTH-1:0]  buf_user_q [6];

    logic [DATA_WIDTH-1:0]  m_data_q;
    logic                   m_valid_q, m_last_q;
    logic [USER_WIDTH-1:0]  m_user_q;
    logic                   accept_q, addr_q, runt_q, ovf_q;
    logic [COUNT_WIDTH-1:0] drop_cnt_q;

    logic                   shift_en, out_valid_d;
    logic                   ev_accept, ev_addr, ev_runt, ev_ovf, hdr_done;
    logic [47:0]            dest;
    logic                   is_bcast, match;

    // Beats 1..5 sit in entries 1..5 when beat 6 is on the input.
    assign dest     = {buf_data_q[1], buf_data_q[2], buf_data_q[3],
                       buf_data_q[4], buf_data_q[5], s_axis_tdata};
    assign is_bcast = &dest;
    assign match    = cfg_promisc | (dest == cfg_local_mac) |
                      (cfg_bcast_enable & is_bcast) |
                      (cfg_mcast_enable & buf_data_q[1][0] & ~is_bcast);
    assign hdr_done = (state_q == ST_HEADER) & s_axis_tvalid & ~s_axis_tlast & (cnt_q == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESYNC;
            cnt_q      <= '0;
            gap_q      <= '0;
            ovf_seen_q <= 1'b0;
            ovf_open_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            ovf_seen_q <= ovf_seen_d;
            ovf_open_q <= ovf_open_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        ovf_seen_d = ovf_seen_q;
        ovf_open_d = ovf_open_q;
        case (state_q)
            ST_RESYNC: begin
                if (s_axis_tvalid) begin
                    gap_d = '0;
                    if (s_axis_tlast) state_d = ST_IDLE;
                end else if (gap_q == GAP_W'(IDLE_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_IDLE: begin
                if (s_axis_tvalid && !s_axis_tlast) begin
                    state_d = ST_HEADER;
                    cnt_d   = 3'd1;
                end
            end
            ST_HEADER: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast)        state_d = ST_IDLE;
                    else if (cnt_q == 3'd5)  state_d = match ? ST_PASS : ST_DROP;
                    else                     cnt_d   = cnt_q + 3'd1;
                end
            end
            ST_PASS: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d    = ST_DRAIN;
                    cnt_d      = '0;
                    ovf_seen_d = 1'b0;
                    ovf_open_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // An intruding frame still open when drain ends is dropped to its tlast.
                if (s_axis_tvalid) begin
                    ovf_seen_d = 1'b1;
                    ovf_open_d = ~s_axis_tlast;
                end
                if (cnt_q == 3'd5) state_d = ovf_open_d ? ST_DROP : ST_IDLE;
                else               cnt_d   = cnt_q + 3'd1;
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_RESYNC;
        endcase
    end

    always_comb begin
        ev_accept   = hdr_done & match;
        ev_addr     = hdr_done & ~match;
        ev_runt     = ((state_q == ST_IDLE) | (state_q == ST_HEADER)) & s_axis_tvalid & s_axis_tlast;
        ev_ovf      = (state_q == ST_DRAIN) & s_axis_tvalid & ~ovf_seen_q;
        out_valid_d = ((state_q == ST_PASS) & s_axis_tvalid) | (state_q == ST_DRAIN);
        shift_en    = (((state_q == ST_IDLE) | (state_q == ST_HEADER) | (state_q == ST_PASS))
                       & s_axis_tvalid) | (state_q == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
                buf_user_q[i] <= '0;
            end
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_user_q   <= '0;
            accept_q   <= 1'b0;
            addr_q     <= 1'b0;
            runt_q     <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (shift_en) begin
                for (int i = 0; i < 5; i++) begin
                    buf_data_q[i] <= buf_data_q[i+1];
                    buf_last_q[i] <= buf_last_q[i+1];
                    buf_user_q[i] <= buf_user_q[i+1];
                end
                buf_data_q[5] <= s_axis_tdata;
                buf_last_q[5] <= s_axis_tlast;
                buf_user_q[5] <= s_axis_tuser;
            end
            m_valid_q <= out_valid_d;
            if (out_valid_d) begin
                m_data_q <= buf_data_q[0];
                m_last_q <= buf_last_q[0];
                m_user_q <= buf_user_q[0];
            end
            accept_q <= ev_accept;
            addr_q   <= ev_addr;
            runt_q   <= ev_runt;
            ovf_q    <= ev_ovf;
            if ((ev_addr | ev_runt | ev_ovf) && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign m_axis_tdata      = m_data_q;
    assign m_axis_tvalid     = m_valid_q;
    assign m_axis_tlast      = m_last_q;
    assign m_axis_tuser      = m_user_q;
    assign stat_frame_accept = accept_q;
    assign stat_drop_addr    = addr_q;
    assign stat_drop_runt    = runt_q;
    assign stat_overflow     = ovf_q;
    assign stat_drop_count   = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_eth_rx_mac_filter.sv
// ============================================================================
// tb_axis_eth_rx_mac_filter : directed self-checking bench for the MAC filter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_eth_rx_mac_filter;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0;
    logic [0:0]    s_tuser = '0;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tlast;
    logic [0:0]    m_tuser;
    logic [47:0]   local_mac = 48'h02_00_00_00_00_01;
    logic          promisc = 1'b0, bcast_en = 1'b0, mcast_en = 1'b0;
    logic          st_acc, st_addr, st_runt, st_ovf;
    logic [CW-1:0] st_cnt;

    axis_eth_rx_mac_filter #(
        .DATA_WIDTH (8),
        .USER_WIDTH (1),
        .COUNT_WIDTH(CW),
        .IDLE_GAP   (16)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_tdata),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tlast     (s_tlast),
        .s_axis_tuser     (s_tuser),
        .m_axis_tdata     (m_tdata),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tlast     (m_tlast),
        .m_axis_tuser     (m_tuser),
        .cfg_local_mac    (local_mac),
        .cfg_promisc      (promisc),
        .cfg_bcast_enable (bcast_en),
        .cfg_mcast_enable (mcast_en),
        .stat_frame_accept(st_acc),
        .stat_drop_addr   (st_addr),
        .stat_drop_runt   (st_runt),
        .stat_overflow    (st_ovf),
        .stat_drop_count  (st_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    int          first_in_cyc = 0, first_out_cyc = -1;
    int          n_acc = 0, n_addr = 0, n_runt = 0, n_ovf = 0;
    logic [9:0]  out_q [$];
    logic [9:0]  sent_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture forwarded beats as {data, last, user} and tally stat pulses.
    always @(negedge clk) begin
        if (m_tvalid) begin
            if (out_q.size() == 0) first_out_cyc = cyc;
            out_q.push_back({m_tdata, m_tlast, m_tuser});
        end
        if (st_acc)  n_acc++;
        if (st_addr) n_addr++;
        if (st_runt) n_runt++;
        if (st_ovf)  n_ovf++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l, input logic u);
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
    endtask

    task automatic send_frame(input int len, input logic [47:0] da, input int seed,
                              input bit gapped, input logic lastuser, input bit rec);
        logic [7:0] b;
        logic       l, u;
        for (int i = 0; i < len; i++) begin
            if (i < 6) b = da[47-8*i -: 8];
            else       b = 8'(i * 7 + seed);
            l = (i == len - 1);
            u = l ? lastuser : 1'b0;
            if (rec) sent_q.push_back({b, l, u});
            if (i == 0) first_in_cyc = cyc;
            beat(b, l, u);
            if (gapped && !l) idle(1);
        end
    endtask

    task automatic clr_stats();
        n_acc = 0; n_addr = 0; n_runt = 0; n_ovf = 0;
    endtask

    task automatic check_frame(input string tag, input bit fwd);
        int bad;
        idle(12);
        bad = 0;
        if (fwd) begin
            check({tag, " len"}, 64'(out_q.size()), 64'(sent_q.size()));
            for (int i = 0; i < out_q.size() && i < sent_q.size(); i++)
                if (out_q[i] !== sent_q[i]) bad++;
            check({tag, " beats"}, 64'(bad), 64'd0);
        end else begin
            check({tag, " no output"}, 64'(out_q.size()), 64'd0);
        end
        out_q.delete();
        sent_q.delete();
    endtask

    initial begin
        idle(3);
        check("reset tvalid", 64'(m_tvalid), 64'd0);
        check("reset stats", {60'd0, st_acc, st_addr, st_runt, st_ovf}, 64'd0);
        check("reset count", 64'(st_cnt), 64'd0);
        rst_n = 1'b1;
        idle(20);

        // Unicast match, 64 bytes
        clr_stats();
        send_frame(64, 48'h02_00_00_00_00_01, 1, 0, 1'b0, 1);
        idle(1);
        check("uni latency", 64'(first_out_cyc - first_in_cyc), 64'd7);
        check_frame("uni", 1);
        check("uni accept", 64'(n_acc), 64'd1);

        // Address mismatch
        clr_stats();
        send_frame(64, 48'h02_00_00_00_00_02, 2, 0, 1'b0, 1);
        check_frame("mismatch", 0);
        check("mismatch pulse", 64'(n_addr), 64'd1);
        check("mismatch count", 64'(st_cnt), 64'd1);

        // Broadcast disabled then enabled
        send_frame(64, 48'hFF_FF_FF_FF_FF_FF, 3, 0, 1'b0, 1);
        check_frame("bcast off", 0);
        check("bcast off count", 64'(st_cnt), 64'd2);
        bcast_en = 1'b1;
        send_frame(64, 48'hFF_FF_FF_FF_FF_FF, 4, 0, 1'b0, 1);
        check_frame("bcast on", 1);
        bcast_en = 1'b0;

        // Multicast disabled then enabled
        send_frame(64, 48'h01_00_5E_00_00_01, 5, 0, 1'b0, 1);
        check_frame("mcast off", 0);
        check("mcast off count", 64'(st_cnt), 64'd3);
        mcast_en = 1'b1;
        send_frame(64, 48'h01_00_5E_00_00_01, 6, 0, 1'b0, 1);
        check_frame("mcast on", 1);
        mcast_en = 1'b0;

        // Promiscuous
        promisc = 1'b1;
        send_frame(64, 48'h0A_0B_0C_0D_0E_0F, 7, 0, 1'b0, 1);
        check_frame("promisc", 1);
        promisc = 1'b0;

        // Runts of 5 and 6 bytes
        clr_stats();
        send_frame(5, 48'h02_00_00_00_00_01, 8, 0, 1'b0, 1);
        check_frame("runt5", 0);
        check("runt5 pulse", 64'(n_runt), 64'd1);
        clr_stats();
        send_frame(6, 48'h02_00_00_00_00_01, 9, 0, 1'b0, 1);
        check_frame("runt6", 0);
        check("runt6 pulse", 64'(n_runt), 64'd1);
        check("runt count", 64'(st_cnt), 64'd5);

        // Bad-frame flag is forwarded on the tlast beat
        send_frame(60, 48'h02_00_00_00_00_01, 10, 0, 1'b1, 1);
        idle(12);
        if (out_q.size() == 0) check("err tuser", 64'd0, 64'd1);
        else                   check("err tuser", 64'(out_q[out_q.size()-1][0]), 64'd1);
        check_frame("err frame", 1);

        // Gapped input
        send_frame(64, 48'h02_00_00_00_00_01, 11, 1, 1'b0, 1);
        check_frame("gapped", 1);

        // Second frame arriving 2 cycles after tlast
        clr_stats();
        send_frame(64, 48'h02_00_00_00_00_01, 12, 0, 1'b0, 1);
        idle(1);
        send_frame(20, 48'h02_00_00_00_00_01, 13, 0, 1'b0, 0);
        check_frame("ovf", 1);
        check("ovf pulse", 64'(n_ovf), 64'd1);
        check("ovf accepts", 64'(n_acc), 64'd1);
        check("ovf count", 64'(st_cnt), 64'd6);

        // Reset at byte 20 of 64
        for (int i = 0; i < 20; i++)
            beat((i < 6) ? local_mac[47-8*i -: 8] : 8'(i + 100), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst tvalid", 64'(m_tvalid), 64'd0);
        check("midrst count", 64'(st_cnt), 64'd0);
        idle(2);
        rst_n = 1'b1;
        out_q.delete();
        for (int i = 20; i < 64; i++) beat(8'(i + 100), (i == 63), 1'b0);
        check_frame("midrst rest", 0);
        idle(18);
        send_frame(64, 48'h02_00_00_00_00_01, 14, 0, 1'b0, 1);
        check_frame("post reset", 1);

        // Counter saturation
        for (int k = 0; k < 6; k++) begin
            send_frame(2, 48'h02_00_00_00_00_01, 15, 0, 1'b0, 0);
            idle(2);
        end
        idle(2);
        check("count 6", 64'(st_cnt), 64'd6);
        for (int k = 0; k < 3; k++) begin
            send_frame(1, 48'h02_00_00_00_00_01, 16, 0, 1'b0, 0);
            idle(2);
        end
        idle(2);
        check("count sat", 64'(st_cnt), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_eth_rx_mac_filter.md
Name: axis_eth_rx_mac_filter

Overview:
- Destination-MAC address filter directly downstream of the GMII frame receiver.
- Consumes its byte-wide AXI stream, which has no tready. Holds the first 6 bytes of each frame, compares the destination address against local, broadcast and multicast rules, then forwards or discards the whole frame.
- Output is a byte stream of identical format, also without backpressure, feeding the RX FIFO.

Parameters:
DATA_WIDTH, 8, stream width; only 8 is supported, any other value fails elaboration
USER_WIDTH, 1, tuser width; bit 0 is the bad-frame flag, upper bits are carried unchanged
COUNT_WIDTH, 32, width of the saturating drop counter
IDLE_GAP, 16, consecutive tvalid-low cycles that end the RESYNC state

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  8  frame byte
s_axis_tvalid  input  1  byte valid
s_axis_tlast  input  1  last byte of frame
s_axis_tuser  input  USER_WIDTH  bit 0 = bad frame, valid on the tlast beat
m_axis_tdata  output  8  forwarded byte
m_axis_tvalid  output  1  forwarded byte valid
m_axis_tlast  output  1  last forwarded byte
m_axis_tuser  output  USER_WIDTH  forwarded tuser
cfg_local_mac  input  48  station address; [47:40] is the first byte on the wire
cfg_promisc  input  1  accept all frames
cfg_bcast_enable  input  1  accept FF:FF:FF:FF:FF:FF
cfg_mcast_enable  input  1  accept group addresses (first byte bit 0 = 1) other than broadcast
stat_frame_accept  output  1  1-cycle pulse when a frame is accepted
stat_drop_addr  output  1  1-cycle pulse when a frame is dropped for address mismatch
stat_drop_runt  output  1  1-cycle pulse when tlast arrives within the first 6 beats
stat_overflow  output  1  1-cycle pulse when a new frame arrives during drain
stat_drop_count  output  COUNT_WIDTH  saturating count of all dropped frames

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; stat_drop_count is 0.
  - State goes to RESYNC.
- Buffer: 6-entry shift register of {tdata, tlast, tuser}.
  - Advances only on an s_axis_tvalid beat (in HEADER/PASS) or on a drain cycle.
- States:
  - RESYNC: discard beats. Go to IDLE on a tlast beat, or after IDLE_GAP consecutive cycles with tvalid low.
  - IDLE: the first valid beat is stored as entry 0; go to HEADER.
  - HEADER: store beats 2..6.
    - tlast on any of beats 1..6: pulse stat_drop_runt, increment counter, go to IDLE; nothing is output.
    - On beat 6 without tlast, evaluate the address at the same clock edge:
      - match = cfg_promisc | (dest==cfg_local_mac) | (cfg_bcast_enable & dest==all-ones) | (cfg_mcast_enable & byte0[0] & dest!=all-ones).
      - Match: pulse stat_frame_accept, go to PASS.
      - No match: pulse stat_drop_addr, increment counter, go to DROP.
    - cfg_* is sampled only at this evaluation edge.
  - PASS: each valid input beat shifts in; the oldest entry is registered onto m_axis the next cycle with tvalid=1.
    - Output beats track input beats 1:1, delayed 6 beats.
    - On the tlast input beat, go to DRAIN.
  - DRAIN: emit the 6 remaining entries on 6 consecutive cycles.
    - The last one carries tlast=1 and the input tlast-beat tuser.
    - Then go to IDLE. Output beat count equals input beat count.
    - A valid input beat during DRAIN: pulse stat_overflow once, increment counter, discard the beat. Drain continues; go to DROP after drain completes, or to IDLE if that beat was tlast.
  - DROP: discard until a tlast beat, then go to IDLE.
- m_axis_tvalid is 0 in every cycle not listed above. tdata/tlast/tuser are don't-care when tvalid=0.
- tuser travels with its byte unchanged; bad-frame frames are forwarded, not dropped.
- Counter saturates at all-ones. Simultaneous drop events in one cycle count once.
- rst_n asserted mid-frame: output stops immediately, with no tlast emitted.

Test Plan:
- Unicast match: cfg_local_mac=02:00:00:00:00:01, 64-byte frame to that DA -> 64 output beats, bytes identical, first output 7 cycles after the first input, tlast on beat 64, stat_frame_accept pulses once.
- Mismatch and broadcast:
  - DA 02:00:00:00:00:02 -> no output, stat_drop_addr pulse, count=1.
  - Broadcast DA with cfg_bcast_enable=0 -> dropped.
  - Broadcast DA with cfg_bcast_enable=1 -> forwarded.
- Multicast/promiscuous: DA 01:00:5E:00:00:01 is dropped with mcast=0 and forwarded with mcast=1; any DA with cfg_promisc=1 is forwarded.
- Runt and error passthrough:
  - 5-byte frame -> no output, stat_drop_runt pulse.
  - 6-byte frame -> no output, stat_drop_runt pulse.
  - Accepted 60-byte frame with tuser=1 on tlast -> output tlast beat has tuser=1.
- Gapped input and overflow:
  - Accepted frame with tvalid low every other cycle -> bytes in order, no duplicates.
  - Second frame starting 2 cycles after tlast -> stat_overflow pulse, first frame fully drained, second frame absent.
- Reset mid-frame: rst_n=0 at byte 20 of 64, released -> outputs 0; the remainder is discarded. The next frame after IDLE_GAP idle cycles is forwarded; counter saturates when preset near all-ones.
